// File: rtl/bus_ctrl.sv
// Registered single-outstanding bus controller: decodes master requests onto
// NSLV address windows, pulses the selected slave and returns a registered response.
module bus_ctrl #(
  parameter int                 NSLV     = 5,
  parameter logic [NSLV*32-1:0] SLV_BASE = {NSLV{32'h0}},
  parameter logic [NSLV*32-1:0] SLV_TOP  = {NSLV{32'h0}},
  parameter int                 TIMEOUT  = 1024
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               mem_valid,
  input  logic               mem_instr,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        mem_wdata,
  input  logic [3:0]         mem_wstrb,
  output logic [31:0]        mem_rdata,
  output logic               mem_error,
  output logic               mem_ready,
  output logic [NSLV-1:0]    slv_valid,
  output logic               slv_instr,
  output logic [31:0]        slv_addr,
  output logic [31:0]        slv_wdata,
  output logic [3:0]         slv_wstrb,
  input  logic [NSLV*32-1:0] slv_rdata,
  input  logic [NSLV-1:0]    slv_ready,
  output logic [15:0]        err_count,
  output logic               busy
);

  localparam int          SW       = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t         state_q, state_d;
  logic [SW-1:0]  sel_q, sel_d;
  logic [15:0]    cnt_q, cnt_d;
  logic [NSLV-1:0] slv_valid_q, slv_valid_d;
  logic           slv_instr_q, slv_instr_d;
  logic [31:0]    slv_addr_q, slv_addr_d;
  logic [31:0]    slv_wdata_q, slv_wdata_d;
  logic [3:0]     slv_wstrb_q, slv_wstrb_d;
  logic [31:0]    mem_rdata_q, mem_rdata_d;
  logic           mem_error_q, mem_error_d;
  logic           mem_ready_q, mem_ready_d;
  logic [15:0]    err_count_q, err_count_d;
  logic           busy_q, busy_d;

  logic           hit;
  logic [SW-1:0]  hit_idx;
  logic [31:0]    hit_base;
  logic [31:0]    sel_rdata;
  logic           sel_ready;
  logic           err_inc;

  // Scan from the top index down so the lowest matching window wins.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_base = 32'h0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if (SLV_BASE[32*i +: 32] <= mem_addr && mem_addr < SLV_TOP[32*i +: 32]) begin
        hit      = 1'b1;
        hit_idx  = SW'(i);
        hit_base = SLV_BASE[32*i +: 32];
      end
    end
  end

  always_comb begin
    sel_rdata = 32'h0;
    sel_ready = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      if (sel_q == SW'(i)) begin
        sel_rdata = slv_rdata[32*i +: 32];
        sel_ready = slv_ready[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    slv_valid_d = '0;
    slv_instr_d = slv_instr_q;
    slv_addr_d  = slv_addr_q;
    slv_wdata_d = slv_wdata_q;
    slv_wstrb_d = slv_wstrb_q;
    mem_rdata_d = mem_rdata_q;
    mem_error_d = mem_error_q;
    mem_ready_d = 1'b0;
    busy_d      = busy_q;
    err_inc     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mem_valid) begin
          if (hit) begin
            slv_valid_d[hit_idx] = 1'b1;
            slv_instr_d = mem_instr;
            slv_addr_d  = mem_addr - hit_base;
            slv_wdata_d = mem_wdata;
            slv_wstrb_d = mem_wstrb;
            sel_d       = hit_idx;
            cnt_d       = 16'h0;
            busy_d      = 1'b1;
            state_d     = BUSY;
          end else begin
            mem_ready_d = 1'b1;
            mem_error_d = 1'b1;
            mem_rdata_d = 32'h0;
            err_inc     = 1'b1;
          end
        end
      end
      BUSY: begin
        // The counter holds through the pulse cycle so the timeout lands TIMEOUT+1 after it.
        if (slv_valid_q == '0) cnt_d = cnt_q + 16'h1;
        if (sel_ready) begin
          mem_ready_d = 1'b1;
          mem_error_d = 1'b0;
          mem_rdata_d = sel_rdata;
          state_d     = RESP;
        end else if (cnt_q == CNT_LAST) begin
          mem_ready_d = 1'b1;
          mem_error_d = 1'b1;
          mem_rdata_d = 32'h0;
          err_inc     = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    err_count_d = (err_inc && err_count_q != 16'hFFFF) ? err_count_q + 16'h1 : err_count_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      cnt_q       <= 16'h0;
      slv_valid_q <= '0;
      slv_instr_q <= 1'b0;
      slv_addr_q  <= 32'h0;
      slv_wdata_q <= 32'h0;
      slv_wstrb_q <= 4'h0;
      mem_rdata_q <= 32'h0;
      mem_error_q <= 1'b0;
      mem_ready_q <= 1'b0;
      err_count_q <= 16'h0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      slv_valid_q <= slv_valid_d;
      slv_instr_q <= slv_instr_d;
      slv_addr_q  <= slv_addr_d;
      slv_wdata_q <= slv_wdata_d;
      slv_wstrb_q <= slv_wstrb_d;
      mem_rdata_q <= mem_rdata_d;
      mem_error_q <= mem_error_d;
      mem_ready_q <= mem_ready_d;
      err_count_q <= err_count_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_rdata = mem_rdata_q;
  assign mem_error = mem_error_q;
  assign mem_ready = mem_ready_q;
  assign slv_valid = slv_valid_q;
  assign slv_instr = slv_instr_q;
  assign slv_addr  = slv_addr_q;
  assign slv_wdata = slv_wdata_q;
  assign slv_wstrb = slv_wstrb_q;
  assign err_count = err_count_q;
  assign busy      = busy_q;

endmodule

// File: doc/bus_ctrl.md
Name: bus_ctrl

Overview:
- Registered single-outstanding bus controller between the arbiter's `memory_*` master port and NSLV memory-mapped slaves (rom, uart, clint, clic, bram, …).
- Decodes the address against per-slave windows and issues a one-cycle request pulse to the selected slave with a base-relative address.
- Waits for that slave's ready, or a timeout, then returns a registered response.
- Replaces the ad-hoc combinational decode/mux and adds decode-error and timeout handling.

Parameters:
- NSLV, 5, number of slaves; slave i uses bit/slice i of every packed slave bus.
- SLV_BASE, {NSLV{32'h0}}, packed NSLV×32: inclusive base address of slave i (slice i = bits 32i+31:32i).
- SLV_TOP, {NSLV{32'h0}}, packed NSLV×32: exclusive top address of slave i.
- TIMEOUT, 1024, cycles from request pulse to forced error response; legal range 2..65535.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- mem_valid  in  1  request strobe from master, one cycle
- mem_instr  in  1  instruction-fetch flag
- mem_addr  in  32  absolute byte address
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte strobes; 0 = read
- mem_rdata  out  32  response data
- mem_error  out  1  response is an error (decode miss or timeout)
- mem_ready  out  1  response strobe, one cycle
- slv_valid  out  NSLV  one-hot request pulse
- slv_instr  out  1  registered mem_instr
- slv_addr  out  32  registered mem_addr − SLV_BASE[sel]
- slv_wdata  out  32  registered mem_wdata
- slv_wstrb  out  4  registered mem_wstrb
- slv_rdata  in  NSLV×32  slave read data, slice i
- slv_ready  in  NSLV  slave response strobes
- err_count  out  16  saturating count of error responses
- busy  out  1  high while a transaction is outstanding

Behaviour:
- **Reset** (reset=1 at posedge): state=IDLE; mem_rdata=0; mem_error=0; mem_ready=0; slv_valid=0; slv_instr=0; slv_addr=0; slv_wdata=0; slv_wstrb=0; err_count=0; busy=0; timeout counter=0. Reset mid-transaction abandons it; no response is ever issued for it.
- **Decode** (combinational on mem_addr): slave i hits if SLV_BASE[i] <= mem_addr < SLV_TOP[i], unsigned compare. On overlapping windows the lowest index wins. A window with base >= top never hits.
- **States**: IDLE, BUSY, RESP.
- **IDLE**, mem_valid=1 and a hit on slave i:
  - Next cycle: slv_valid[i]=1 for exactly that cycle; slv_* payload registered.
  - sel<=i; counter<=0; busy<=1; state<=BUSY.
- **IDLE**, mem_valid=1 and no hit:
  - No slv_valid.
  - Next cycle: mem_ready=1, mem_error=1, mem_rdata=0; err_count increments.
  - State stays IDLE (response issued directly from IDLE).
- **BUSY**:
  - Counter increments each cycle.
  - If slv_ready[sel]=1: latch slv_rdata slice sel; state<=RESP.
  - Else if counter==TIMEOUT−1: state<=RESP with error flag set, rdata=0.
  - Ready arriving on the same cycle as the timeout wins (normal response).
- **RESP**: mem_ready=1 for one cycle with latched rdata/error; err_count increments if error; busy<=0; state<=IDLE.
- **Latency**:
  - Decode error: mem_ready 1 cycle after mem_valid.
  - Hit: request pulse at +1; if the slave is ready on cycle k after the pulse (k>=0), mem_ready at pulse+k+1.
  - Earliest response (slave ready in the pulse cycle) = 2 cycles after mem_valid.
  - Timeout response = TIMEOUT+1 cycles after the pulse.
- **Ignored inputs**:
  - slv_ready from non-selected slaves, and any slv_ready in IDLE/RESP (including late ready from a timed-out slave), is ignored.
  - mem_valid while busy=1 or in RESP is ignored. The master guarantees one outstanding request; the bench flags a violation.
- **Other rules**: err_count saturates at 16'hFFFF. slv_addr subtraction is 32-bit modulo. Only one slv_valid bit is ever high.

Test Plan:
- **Basic read**: SLV_BASE[4]=0x80000000, TOP=0x80100000; read 0x80000010; slave 4 ready 3 cycles after its pulse with 0xDEADBEEF -> slv_valid=5'b10000 pulse, slv_addr=0x10, mem_ready 4 cycles after pulse with rdata 0xDEADBEEF, error=0.
- **Write to uart**: slave 1 window 0x10000000..0x10001000; write wdata=0x41, wstrb=4'b0001 to 0x10000000; ready in pulse cycle -> slv_wdata=0x41, slv_wstrb=1, mem_ready 2 cycles after mem_valid.
- **Decode miss**: access 0x00000004 with no window covering it -> no slv_valid; mem_ready=1, mem_error=1 next cycle; err_count=1.
- **Timeout then late ready**: TIMEOUT=8, slave never ready -> error response at pulse+9. Slave 2 ready 3 cycles later -> ignored. A following valid request completes normally.
- **Ready vs timeout**: ready on exactly counter==TIMEOUT−1 -> normal response with data, err_count unchanged.
- **Reset and saturation**: assert reset while BUSY -> all outputs 0 next cycle, no mem_ready. Separately, preload 65535 errors, one more miss -> err_count stays 0xFFFF.
